apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB master: a small command FIFO feeding a single-outstanding APB transfer FSM.
// Reads hold in RD_WAIT for READ_LAT cycles before prdata is captured.
module apb_master #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic [15:0] wr_cnt,
    output logic [15:0] rd_cnt,
    output logic [7:0]  paddr,
    output logic        pwrite,
    output logic        psel,
    output logic        penable,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RD_WAIT} state_e;

    typedef struct packed {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    localparam int unsigned PW        = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT  = (PW+1)'(CMD_DEPTH);
    localparam logic [1:0]  LAST_WAIT = 2'(READ_LAT - 1);

    cmd_t          fifo_q [CMD_DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          push, pop, fifo_empty;

    state_e        state_q, state_d;
    logic [1:0]    wait_q, wait_d;
    logic          start;
    logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [7:0]    paddr_q, paddr_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [15:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

    assign cmd_ready  = (count_q != FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_q[rd_ptr_q];
    assign busy       = (state_q != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        start       = 1'b0;
        pop         = 1'b0;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        case (state_q)
            IDLE: begin
                start = !fifo_empty;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (pwrite_q) begin
                    wr_cnt_d = wr_cnt_q + 16'd1;
                    start    = !fifo_empty;
                    state_d  = IDLE;
                end else begin
                    wait_d  = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = prdata;
                    rd_cnt_d    = rd_cnt_q + 16'd1;
                    start       = !fifo_empty;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Every route into SETUP (from IDLE, write ACCESS, end of RD_WAIT) pops here.
        if (start) begin
            pop       = 1'b1;
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = head.write;
            paddr_d   = head.addr;
            pwdata_d  = head.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign wr_cnt    = wr_cnt_q;
    assign rd_cnt    = rd_cnt_q;

endmodule
